adder_rr_scheduler: RTL and testbench
=====================================

# adder_rr_scheduler

Round-robin scheduler that shares one registered 8-bit ripple-carry adder (`eight_bit_adder`, instanced internally) between `N_REQ` requesters. Each requester offers an operand pair plus carry-in over a valid/ready handshake. The block grants one requester at a time, drives the adder, and returns the sum, carry-out and requester index on a single valid/ready response port. It sits between client logic and the shared adder datapath.

## Interface
- `N_REQ`, default 4, number of requesters; legal range 2..8.
- `ID_W`, default 2, width of `rsp_id`; must equal ceil(log2(`N_REQ`)); 1 when `N_REQ`=2.
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  reset, synchronous, active-low; also drives the internal adder's `rst`.
- `req_valid`  in  `N_REQ`  bit i: requester i has an operation pending.
- `req_a`  in  8*`N_REQ`  operand A; requester i uses bits [8i+7:8i].
- `req_b`  in  8*`N_REQ`  operand B; same packing as `req_a`.
- `req_cin`  in  `N_REQ`  carry-in; bit i for requester i.
- `req_ready`  out  `N_REQ`  bit i: requester i accepted this cycle. Zero-or-one-hot.
- `rsp_valid`  out  1  response available.
- `rsp_sum`  out  8  sum[7:0].
- `rsp_cout`  out  1  carry-out of bit 7.
- `rsp_id`  out  `ID_W`  index of the requester this response belongs to.
- `rsp_ready`  in  1  consumer accepts the response.
- `busy`  out  1  high whenever state is not IDLE.

## Operation
- FSM states: IDLE, CALC, RESP.
- **IDLE**
  - If any `req_valid` is set, select grant g by round-robin: search from (`last_ptr`+1) mod `N_REQ` upward, wrapping.
  - Assert `req_ready[g]` combinationally in the same cycle.
  - At the clock edge, capture `req_a`/`req_b`/`req_cin` of g into operand registers, store g in the id register, set `last_ptr`=g, and go to CALC.
  - If no `req_valid` is set, stay in IDLE; `last_ptr` is unchanged.
- **CALC**
  - Operand registers drive the adder.
  - At the edge the adder registers `sum`/`cout`; go to RESP.
- **RESP**
  - `rsp_valid`=1. `rsp_sum`/`rsp_cout` come from adder `sum_r`/`cout_r`; `rsp_id` comes from the id register.
  - Operand registers are held, so outputs stay stable.
  - Stay in RESP while `rsp_ready`=0.
  - On `rsp_valid` & `rsp_ready`, go to IDLE.
- `req_ready` is 0 in CALC and RESP.
- Operand and id registers change only on an IDLE accept.
- Arithmetic: {`rsp_cout`,`rsp_sum`} = A + B + cin, modulo 512. 0xFF+0xFF+1 = {1,0xFF}.
- Requesters hold `req_valid` and operands until `req_ready`. A requester that drops `req_valid` before it is granted is skipped, with no side effect.
- `req_valid` changing in CALC or RESP has no effect until the next IDLE.
- Reset (`rst`=0 at an edge), in any state including mid-operation:
  - state goes to IDLE, `last_ptr`=`N_REQ`-1, operand/id registers are cleared, and the adder output registers clear.
  - The in-flight operation is dropped and produces no response.
- Reset values of outputs: `req_ready`=0, `rsp_valid`=0, `rsp_sum`=0x00, `rsp_cout`=0, `rsp_id`=0, `busy`=0.

## Timing
- Accept edge at T: the cycle where `req_ready[g]`=1.
- CALC occupies cycle T+1.
- `rsp_valid` first asserts in cycle T+2. Latency from accept to response is 2 cycles.
- With `rsp_ready` tied high:
  - RESP lasts 1 cycle, IDLE 1 cycle.
  - Accepts fall every 3 cycles. Peak throughput is 1 op / 3 cycles.
- Each cycle `rsp_ready` is low in RESP adds exactly one cycle.
- Fairness: with all requesters continuously valid, grants cycle 0,1,…,`N_REQ`-1,0,…
  - Any requester waits at most `N_REQ`-1 other operations.
- `req_ready` depends combinationally on `req_valid` and state. No other output is combinational from inputs.

## Test plan
- Single op: after reset, requester 2 with A=0x35, B=0x4A, cin=0.
  - `req_ready`=0b0100 in that cycle.
  - 2 cycles later: `rsp_valid`=1, sum=0x7F, cout=0, id=2. Then IDLE and `busy`=0.
- Carry boundary: A=0xFF, B=0x01, cin=1 → sum=0x01, cout=1. A=0xFF, B=0xFF, cin=1 → sum=0xFF, cout=1.
- Contention: all 4 requesters valid from reset, `rsp_ready`=1.
  - Grant order 0,1,2,3,0.
  - Accepts spaced exactly 3 cycles apart.
  - Each `rsp_id` matches the corresponding grant, and each sum is correct per requester.
- Backpressure: hold `rsp_ready`=0 for 5 cycles in RESP.
  - `rsp_valid`, sum, cout and id stay constant; `req_ready`=0 throughout.
  - Release: IDLE on the next cycle.
- Reset mid-op: assert `rst`=0 during CALC for 1 cycle.
  - No response is ever produced and all outputs take reset values.
  - The next grant with all requesters valid goes to requester 0.
- Fairness skip: requesters 1 and 3 valid, `last_ptr`=1.
  - Grant 3, then 1, then 3; requesters 0 and 2 never get `req_ready`.

Source files
------------

// File: rtl/adder_rr_scheduler.sv
// rtl/adder_rr_scheduler.sv - round-robin scheduler sharing one registered 8-bit adder

module eight_bit_adder (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum_r,
    output logic       cout_r
);

    logic [7:0] sum_c;
    logic       cout_c;

    // Ripple chain kept inside one process so the carry is a local variable.
    always_comb begin
        logic c;
        c     = cin;
        sum_c = '0;
        for (int i = 0; i < 8; i++) begin
            sum_c[i] = a[i] ^ b[i] ^ c;
            c        = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout_c = c;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sum_r  <= '0;
            cout_r <= 1'b0;
        end else begin
            sum_r  <= sum_c;
            cout_r <= cout_c;
        end
    end

endmodule

module adder_rr_scheduler #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_a,
    input  logic [8*N_REQ-1:0]   req_b,
    input  logic [N_REQ-1:0]     req_cin,
    output logic [N_REQ-1:0]     req_ready,
    output logic                 rsp_valid,
    output logic [7:0]           rsp_sum,
    output logic                 rsp_cout,
    output logic [ID_W-1:0]      rsp_id,
    input  logic                 rsp_ready,
    output logic                 busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [ID_W-1:0] last_ptr;
    logic [ID_W-1:0] grant_idx;
    logic            grant_found;
    logic            accept;
    logic [7:0]      op_a;
    logic [7:0]      op_b;
    logic            op_cin;
    logic [ID_W-1:0] id_r;

    // Search starts one past the last grant and wraps; the sum is at most 2*N_REQ-1,
    // so a single conditional subtract yields the modulo.
    always_comb begin
        logic [ID_W:0] cand;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = {1'b0, last_ptr} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(N_REQ))
                cand = cand - (ID_W+1)'(N_REQ);
            if (!grant_found && req_valid[cand[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[ID_W-1:0];
            end
        end
    end

    assign accept = (state == S_IDLE) && grant_found;

    always_ff @(posedge clk) begin
        if (!rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (grant_found) state_nxt = S_CALC;
            S_CALC:  state_nxt = S_RESP;
            S_RESP:  if (rsp_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        rsp_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            S_IDLE: if (grant_found) req_ready = N_REQ'(1) << grant_idx;
            S_CALC: busy = 1'b1;
            S_RESP: begin
                busy      = 1'b1;
                rsp_valid = 1'b1;
            end
            default: ;
        endcase
    end

    // Operand and id registers only move on an accept, so the response holds under backpressure.
    always_ff @(posedge clk) begin
        if (!rst) begin
            last_ptr <= ID_W'(N_REQ - 1);
            op_a     <= '0;
            op_b     <= '0;
            op_cin   <= 1'b0;
            id_r     <= '0;
        end else if (accept) begin
            last_ptr <= grant_idx;
            op_a     <= req_a[{grant_idx, 3'b000} +: 8];
            op_b     <= req_b[{grant_idx, 3'b000} +: 8];
            op_cin   <= req_cin[grant_idx];
            id_r     <= grant_idx;
        end
    end

    eight_bit_adder u_adder (
        .clk    (clk),
        .rst    (rst),
        .a      (op_a),
        .b      (op_b),
        .cin    (op_cin),
        .sum_r  (rsp_sum),
        .cout_r (rsp_cout)
    );

    assign rsp_id = id_r;

endmodule

// File: tb/tb_adder_rr_scheduler.sv
// tb/tb_adder_rr_scheduler.sv - directed checks for adder_rr_scheduler

module tb_adder_rr_scheduler;

    localparam int N_REQ = 4;
    localparam int ID_W  = 2;

    logic               clk;
    logic               rst;
    logic [N_REQ-1:0]   req_valid;
    logic [8*N_REQ-1:0] req_a;
    logic [8*N_REQ-1:0] req_b;
    logic [N_REQ-1:0]   req_cin;
    logic [N_REQ-1:0]   req_ready;
    logic               rsp_valid;
    logic [7:0]         rsp_sum;
    logic               rsp_cout;
    logic [ID_W-1:0]    rsp_id;
    logic               rsp_ready;
    logic               busy;

    int n_tests = 0;
    int n_fail  = 0;

    adder_rr_scheduler #(.N_REQ(N_REQ), .ID_W(ID_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_id    (rsp_id),
        .rsp_ready (rsp_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] exp_sum;
        logic       exp_cout;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b0;
        req_valid = '0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 32'h0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
        check({tag, "_rsp_sum"},   32'(rsp_sum),   32'h0);
        check({tag, "_rsp_cout"},  32'(rsp_cout),  32'h0);
        check({tag, "_rsp_id"},    32'(rsp_id),    32'h0);
        check({tag, "_busy"},      32'(busy),      32'h0);
    endtask

    // Load operands for every requester; requester i uses a_base+i and b_base+2i.
    task automatic load_all(input logic [7:0] a_base, input logic [7:0] b_base);
        for (int i = 0; i < N_REQ; i++) begin
            req_a[8*i +: 8] = a_base + 8'(i);
            req_b[8*i +: 8] = b_base + 8'(2 * i);
            req_cin[i]      = 1'(i & 1);
        end
    endtask

    function automatic logic [8:0] exp_add(input int i, input logic [7:0] a_base, input logic [7:0] b_base);
        return 9'(a_base + 8'(i)) + 9'(b_base + 8'(2 * i)) + 9'(i & 1);
    endfunction

    initial begin
        logic [8:0] e;
        int         waited;
        logic [7:0] hold_sum;
        int         seq[3];

        vecs[0] = '{2, 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0};
        vecs[1] = '{0, 8'hFF, 8'h01, 1'b1, 8'h01, 1'b1};
        vecs[2] = '{1, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{3, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[4] = '{1, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[5] = '{3, 8'h12, 8'h34, 1'b1, 8'h47, 1'b0};
        vecs[6] = '{0, 8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};
        vecs[7] = '{2, 8'h0F, 8'hF0, 1'b1, 8'h00, 1'b1};

        rst       = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_cin   = '0;
        rsp_ready = 1'b1;

        do_reset();
        check_reset_outputs("reset");

        // Table-driven single operations, one requester at a time.
        for (int v = 0; v < 8; v++) begin
            @(negedge clk);
            req_a                      = '0;
            req_b                      = '0;
            req_cin                    = '0;
            req_a[8*vecs[v].id +: 8]   = vecs[v].a;
            req_b[8*vecs[v].id +: 8]   = vecs[v].b;
            req_cin[vecs[v].id]        = vecs[v].cin;
            req_valid                  = N_REQ'(1) << vecs[v].id;
            #1;
            check($sformatf("vec%0d_ready", v), 32'(req_ready), 32'(N_REQ'(1) << vecs[v].id));
            step();
            req_valid = '0;
            #1;
            check($sformatf("vec%0d_calc_busy", v), 32'(busy), 32'h1);
            check($sformatf("vec%0d_calc_valid", v), 32'(rsp_valid), 32'h0);
            step();
            check($sformatf("vec%0d_rsp_valid", v), 32'(rsp_valid), 32'h1);
            check($sformatf("vec%0d_sum", v), 32'(rsp_sum), 32'(vecs[v].exp_sum));
            check($sformatf("vec%0d_cout", v), 32'(rsp_cout), 32'(vecs[v].exp_cout));
            check($sformatf("vec%0d_id", v), 32'(rsp_id), 32'(vecs[v].id));
            step();
            check($sformatf("vec%0d_idle_busy", v), 32'(busy), 32'h0);
            check($sformatf("vec%0d_idle_valid", v), 32'(rsp_valid), 32'h0);
        end

        // Contention: all requesters valid from reset.
        do_reset();
        load_all(8'h10, 8'h03);
        req_valid = '1;
        #1;
        waited = 0;
        while (req_ready == '0 && waited < 10) begin
            step();
            waited++;
        end
        check("cont_first_grant_latency", 32'(waited), 32'h0);
        for (int g = 0; g < 5; g++) begin
            check($sformatf("cont%0d_grant", g), 32'(req_ready), 32'(N_REQ'(1) << (g % N_REQ)));
            step();
            check($sformatf("cont%0d_calc_ready", g), 32'(req_ready), 32'h0);
            step();
            e = exp_add(g % N_REQ, 8'h10, 8'h03);
            check($sformatf("cont%0d_rsp_valid", g), 32'(rsp_valid), 32'h1);
            check($sformatf("cont%0d_rsp_id", g), 32'(rsp_id), 32'(g % N_REQ));
            check($sformatf("cont%0d_rsp_sum", g), 32'(rsp_sum), 32'(e[7:0]));
            check($sformatf("cont%0d_rsp_cout", g), 32'(rsp_cout), 32'(e[8]));
            step();
        end
        req_valid = '0;

        // Backpressure: response held for 5 cycles with rsp_ready low.
        do_reset();
        rsp_ready   = 1'b0;
        req_a[15:8] = 8'h3C;
        req_b[15:8] = 8'h0F;
        req_cin[1]  = 1'b1;
        req_valid   = 4'b0010;
        #1;
        check("bp_grant", 32'(req_ready), 32'h2);
        step();
        req_valid = '1;
        step();
        hold_sum = 8'h4C;
        for (int c = 0; c < 5; c++) begin
            check($sformatf("bp%0d_valid", c), 32'(rsp_valid), 32'h1);
            check($sformatf("bp%0d_sum", c), 32'(rsp_sum), 32'(hold_sum));
            check($sformatf("bp%0d_cout", c), 32'(rsp_cout), 32'h0);
            check($sformatf("bp%0d_id", c), 32'(rsp_id), 32'h1);
            check($sformatf("bp%0d_ready", c), 32'(req_ready), 32'h0);
            if (c < 4) step();
        end
        rsp_ready = 1'b1;
        step();
        req_valid = '0;
        #1;
        check("bp_release_busy", 32'(busy), 32'h0);
        check("bp_release_valid", 32'(rsp_valid), 32'h0);

        // Reset during CALC drops the operation.
        do_reset();
        req_a[23:16] = 8'h01;
        req_b[23:16] = 8'h02;
        req_valid    = 4'b0100;
        #1;
        check("rmid_grant", 32'(req_ready), 32'h4);
        step();
        req_valid = '0;
        rst       = 1'b0;
        #1;
        check("rmid_in_calc", 32'(busy), 32'h1);
        step();
        rst = 1'b1;
        #1;
        check_reset_outputs("rmid");
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("rmid_norsp%0d", c), 32'(rsp_valid), 32'h0);
        end
        req_valid = '1;
        #1;
        check("rmid_next_grant", 32'(req_ready), 32'h1);
        step();
        req_valid = '0;
        step();
        step();

        // Fairness skip: only requesters 1 and 3 valid, last grant was 1.
        do_reset();
        req_valid = 4'b0010;
        #1;
        check("skip_prime", 32'(req_ready), 32'h2);
        step();
        req_valid = 4'b1010;
        step();
        step();
        seq = '{3, 1, 3};
        for (int g = 0; g < 3; g++) begin
            check($sformatf("skip%0d_grant", g), 32'(req_ready), 32'(N_REQ'(1) << seq[g]));
            step();
            check($sformatf("skip%0d_calc_ready", g), 32'(req_ready), 32'h0);
            step();
            check($sformatf("skip%0d_rsp_id", g), 32'(rsp_id), 32'(seq[g]));
            step();
        end
        req_valid = '0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
